// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display blocks: symbol codes,
// active-low segment patterns {g,f,e,d,c,b,a}, one-cold digit enables
// and the display-owner state encoding.
package seg7_pkg;

  // Symbol codes beyond the decimal digits
  localparam logic [3:0] SYM_UP    = 4'd10;
  localparam logic [3:0] SYM_DOWN  = 4'd11;
  localparam logic [3:0] SYM_DASH  = 4'd12;
  localparam logic [3:0] SYM_BIG_P = 4'd13;
  localparam logic [3:0] SYM_EMPTY = 4'd14;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b100_0000;
  localparam logic [6:0] SEG_1     = 7'b111_1001;
  localparam logic [6:0] SEG_2     = 7'b010_0100;
  localparam logic [6:0] SEG_3     = 7'b011_0000;
  localparam logic [6:0] SEG_4     = 7'b001_1001;
  localparam logic [6:0] SEG_5     = 7'b001_0010;
  localparam logic [6:0] SEG_6     = 7'b000_0010;
  localparam logic [6:0] SEG_7     = 7'b111_1000;
  localparam logic [6:0] SEG_8     = 7'b000_0000;
  localparam logic [6:0] SEG_9     = 7'b001_0000;
  localparam logic [6:0] SEG_UP    = 7'b101_1100;
  localparam logic [6:0] SEG_DOWN  = 7'b110_0011;
  localparam logic [6:0] SEG_DASH  = 7'b011_1111;
  localparam logic [6:0] SEG_BIG_P = 7'b000_1100;
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

  // One-cold digit enables (active-low), digit 0 is the rightmost
  localparam logic [3:0] DIG_0   = 4'b1110;
  localparam logic [3:0] DIG_1   = 4'b1101;
  localparam logic [3:0] DIG_2   = 4'b1011;
  localparam logic [3:0] DIG_3   = 4'b0111;
  localparam logic [3:0] DIG_OFF = 4'b1111;

  // Display ownership state
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } owner_t;

  // Map a digit slot index to its one-cold enable
  function automatic logic [3:0] digit_onecold(input logic [1:0] idx);
    logic [3:0] d;
    case (idx)
      2'd0:    d = DIG_0;
      2'd1:    d = DIG_1;
      2'd2:    d = DIG_2;
      default: d = DIG_3;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Pure combinational 4-bit symbol code to active-low 7-segment pattern.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  // Symbol lookup; codes 14 and 15 render blank
  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:      seg = SEG_0;
      4'd1:      seg = SEG_1;
      4'd2:      seg = SEG_2;
      4'd3:      seg = SEG_3;
      4'd4:      seg = SEG_4;
      4'd5:      seg = SEG_5;
      4'd6:      seg = SEG_6;
      4'd7:      seg = SEG_7;
      4'd8:      seg = SEG_8;
      4'd9:      seg = SEG_9;
      SYM_UP:    seg = SEG_UP;
      SYM_DOWN:  seg = SEG_DOWN;
      SYM_DASH:  seg = SEG_DASH;
      SYM_BIG_P: seg = SEG_BIG_P;
      default:   seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_arbiter.sv
// Owns the shared 4-digit seven-segment display: scans the digits,
// decodes the owning client's symbols and arbitrates ownership between
// a main view (A) and an overlay (B) at frame boundaries only.
//
// Request/grant semantics: req_a/req_b are levels sampled only at frame
// boundaries; gnt_a/gnt_b are registered, mutually exclusive and change
// only on the boundary tick. A client that drops req mid-frame keeps its
// grant and its digits until the next boundary. B wins a tie from IDLE;
// a contested holder is pre-empted only after HOLD_FRAMES frames.
module seg7_scan_arbiter
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_PERIOD = 131072,
  parameter int unsigned HOLD_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [15:0] val_a,
  input  logic        req_b,
  input  logic [15:0] val_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        frame,
  output logic [3:0]  DIGIT,
  output logic [6:0]  DISPLAY
);

  localparam int TW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam int HW = $clog2(HOLD_FRAMES) + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_PERIOD - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_FRAMES - 1);

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [1:0]    idx;
  logic [1:0]    idx_nxt;
  logic          boundary;

  owner_t        state;
  owner_t        state_nxt;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_nxt;

  logic [15:0]   owner_val;
  logic [3:0]    nibble;
  logic [6:0]    seg;
  logic [6:0]    disp_nxt;

  assign tick     = (tick_cnt == TICK_LAST);
  assign idx_nxt  = idx + 2'd1;
  assign boundary = tick && (idx == 2'd3);
  assign frame    = boundary;
  assign gnt_a    = (state == OWN_A);
  assign gnt_b    = (state == OWN_B);

  // Digit-slot timer: counts 0..SCAN_PERIOD-1 and wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // Ownership state and hold counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Next owner and hold count, evaluated only at frame boundaries
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    if (boundary) begin
      case (state)
        IDLE: begin
          if (req_b)      state_nxt = OWN_B;
          else if (req_a) state_nxt = OWN_A;
        end
        OWN_A: begin
          if (!req_a)     state_nxt = req_b ? OWN_B : IDLE;
          else if (req_b && (hold_cnt >= HOLD_MAX)) state_nxt = OWN_B;
        end
        OWN_B: begin
          if (!req_b)     state_nxt = req_a ? OWN_A : IDLE;
          else if (req_a && (hold_cnt >= HOLD_MAX)) state_nxt = OWN_A;
        end
        default: state_nxt = IDLE;
      endcase
      if (state_nxt != state) begin
        hold_nxt = '0;
      end else if (hold_cnt < HOLD_MAX) begin
        hold_nxt = hold_cnt + HW'(1);
      end
    end
  end

  // Pick the symbol for the upcoming digit from the (possibly new) owner
  always_comb begin
    owner_val = 16'hFFFF;
    if (state_nxt == OWN_A)      owner_val = val_a;
    else if (state_nxt == OWN_B) owner_val = val_b;
    case (idx_nxt)
      2'd0:    nibble = owner_val[3:0];
      2'd1:    nibble = owner_val[7:4];
      2'd2:    nibble = owner_val[11:8];
      default: nibble = owner_val[15:12];
    endcase
    disp_nxt = (state_nxt == IDLE) ? SEG_BLANK : seg;
  end

  seg7_decoder u_decoder (
    .code (nibble),
    .seg  (seg)
  );

  // Scan position and pin registers, advanced on every tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= 2'd3;
      DIGIT   <= DIG_OFF;
      DISPLAY <= SEG_BLANK;
    end else if (tick) begin
      idx     <= idx_nxt;
      DIGIT   <= digit_onecold(idx_nxt);
      DISPLAY <= disp_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_arbiter.sv
// Directed bench for seg7_scan_arbiter with SCAN_PERIOD=4, HOLD_FRAMES=2.
module tb_seg7_scan_arbiter;

  logic        clk;
  logic        rst;
  logic        req_a;
  logic [15:0] val_a;
  logic        req_b;
  logic [15:0] val_b;
  logic        gnt_a;
  logic        gnt_b;
  logic        frame;
  logic [3:0]  DIGIT;
  logic [6:0]  DISPLAY;

  int errors = 0;
  int checks = 0;

  seg7_scan_arbiter #(
    .SCAN_PERIOD (4),
    .HOLD_FRAMES (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_a   (req_a),
    .val_a   (val_a),
    .req_b   (req_b),
    .val_b   (val_b),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b),
    .frame   (frame),
    .DIGIT   (DIGIT),
    .DISPLAY (DISPLAY)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_digit(input int i);
    logic [3:0] d;
    case (i)
      0:       d = 4'b1110;
      1:       d = 4'b1101;
      2:       d = 4'b1011;
      default: d = 4'b0111;
    endcase
    return d;
  endfunction

  // Apply reset at a falling edge, release two cycles later at a falling edge
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) for a frame pulse, then one more cycle so the boundary
  // effects are visible; reports the number of cycles waited for the pulse
  task automatic next_boundary(output int waited);
    waited = -1;
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      if (frame === 1'b1) begin
        waited = n;
        break;
      end
    end
    if (waited < 0) check("frame_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  logic [6:0] pat_0c12 [4];
  int         w;
  int         idx_e;

  initial begin
    pat_0c12[0] = 7'b010_0100;
    pat_0c12[1] = 7'b111_1001;
    pat_0c12[2] = 7'b011_1111;
    pat_0c12[3] = 7'b100_0000;

    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; val_a = 16'h0000; val_b = 16'h0000;
    step(2);

    // 1: reset values, then free-running scan with no owner
    check("rst_digit", DIGIT, 4'b1111);
    check("rst_display", DISPLAY, 7'h7F);
    check("rst_gnt_a", gnt_a, 0);
    check("rst_gnt_b", gnt_b, 0);
    check("rst_frame", frame, 0);
    rst = 1'b0;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      idx_e = (k < 4) ? 3 : ((k / 4) - 1) % 4;
      check("idle_digit", DIGIT, (k < 4) ? 4'b1111 : exp_digit(idx_e));
      check("idle_display", DISPLAY, 7'h7F);
      check("idle_frame", frame, ((k % 4) == 3) && (idx_e == 3));
      check("idle_gnt", {gnt_a, gnt_b}, 2'b00);
    end

    // 2: client A alone from reset, val_a=0C12
    rst = 1'b1; req_a = 1'b1; val_a = 16'h0C12;
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      idx_e = (k < 4) ? 3 : ((k / 4) - 1) % 4;
      check("a_gnt_a", gnt_a, k >= 4);
      check("a_gnt_b", gnt_b, 0);
      check("a_digit", DIGIT, (k < 4) ? 4'b1111 : exp_digit(idx_e));
      check("a_display", DISPLAY, (k < 4) ? 7'h7F : pat_0c12[idx_e]);
    end

    // 3: both request together from IDLE, B wins; val_b=DCBA shows symbols
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1; val_b = 16'hDCBA;
    do_reset();
    next_boundary(w);
    check("tie_first_tick", w, 3);
    check("tie_gnt_b", gnt_b, 1);
    check("tie_gnt_a", gnt_a, 0);
    check("tie_up", {DIGIT, DISPLAY}, {4'b1110, 7'b101_1100});
    step(4);
    check("tie_down", {DIGIT, DISPLAY}, {4'b1101, 7'b110_0011});
    step(4);
    check("tie_dash", {DIGIT, DISPLAY}, {4'b1011, 7'b011_1111});
    step(4);
    check("tie_p", {DIGIT, DISPLAY}, {4'b0111, 7'b000_1100});

    // 4: owner A, req_b rises mid-frame at hold_cnt=0
    rst = 1'b1; req_a = 1'b1; req_b = 1'b0; val_a = 16'h9876; val_b = 16'hEEEE;
    do_reset();
    next_boundary(w);
    check("hold_gnt_a0", {gnt_a, gnt_b}, 2'b10);
    check("hold_disp_a0", DISPLAY, 7'b000_0010);
    step(5);
    req_b = 1'b1;
    next_boundary(w);
    check("hold_kept", {gnt_a, gnt_b}, 2'b10);
    check("hold_kept_disp", DISPLAY, 7'b000_0010);
    next_boundary(w);
    check("hold_switch", {gnt_a, gnt_b}, 2'b01);
    check("hold_switch_disp", {DIGIT, DISPLAY}, {4'b1110, 7'h7F});

    // 5: owner B drops req mid-frame while A requests; values sampled live
    val_b = 16'h5555;
    step(4);
    check("drop_b_live", {DIGIT, DISPLAY}, {4'b1101, 7'b001_0010});
    req_b = 1'b0;
    step(1);
    check("drop_b_kept_gnt", {gnt_a, gnt_b}, 2'b01);
    check("drop_b_kept_disp", DISPLAY, 7'b001_0010);
    step(3);
    check("drop_b_next_digit", {DIGIT, DISPLAY}, {4'b1011, 7'b001_0010});
    next_boundary(w);
    check("drop_b_to_a", {gnt_a, gnt_b}, 2'b10);
    check("drop_b_a_disp", {DIGIT, DISPLAY}, {4'b1110, 7'b000_0010});
    // fresh grant means hold_cnt=0: a contender waits one more frame
    step(2);
    req_b = 1'b1;
    next_boundary(w);
    check("rehold_kept", {gnt_a, gnt_b}, 2'b10);
    next_boundary(w);
    check("rehold_switch", {gnt_a, gnt_b}, 2'b01);

    // 6: reset pulse mid-frame while B owns the display
    step(6);
    rst = 1'b1;
    #1;
    check("async_digit", DIGIT, 4'b1111);
    check("async_display", DISPLAY, 7'h7F);
    check("async_gnt", {gnt_a, gnt_b}, 2'b00);
    req_b = 1'b0; req_a = 1'b1; val_a = 16'h0C12;
    @(negedge clk);
    check("rst_hold_gnt", {gnt_a, gnt_b}, 2'b00);
    rst = 1'b0;
    next_boundary(w);
    check("rearb_first_tick", w, 3);
    check("rearb_gnt", {gnt_a, gnt_b}, 2'b10);
    check("rearb_disp", {DIGIT, DISPLAY}, {4'b1110, 7'b010_0100});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
